// File: rtl/vmem_pkg.sv
// vmem_pkg: shared widths, FSM states and beat addressing for the vector memory bridge
package vmem_pkg;
    localparam int ADDR_W     = 32;
    localparam int LANES      = 16;
    localparam int LANE_W     = 8;
    localparam int BUS_W      = 32;
    localparam int VEC_W      = LANES * LANE_W;
    localparam int BEATS      = VEC_W / BUS_W;
    localparam int BEAT_IDX_W = $clog2(BEATS);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} vmem_state_t;

    // Word address of beat k; the base's byte offset is dropped and the sum wraps modulo 2^ADDR_W
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base, input logic [BEAT_IDX_W-1:0] k);
        return (base & ~ADDR_W'(3)) + {{(ADDR_W-BEAT_IDX_W-2){1'b0}}, k, 2'b00};
    endfunction
endpackage

// File: rtl/vector_mem_bridge_if.sv
// vector_mem_bridge_if: vector request/response and 32-bit RAM bus of the bridge
//   master: vector pipeline + RAM side; slave: the bridge
//   req_valid/req_ready/req_we/req_addr/data_b  request handshake and store data
//   q_b/done/busy/align_err                     load result, completion, stall, misalignment
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata  RAM word port
interface vector_mem_bridge_if;
    import vmem_pkg::*;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr, mem_addr;
    logic [VEC_W-1:0]  data_b, q_b;
    logic              done, busy, align_err, mem_we, mem_re;
    logic [BUS_W-1:0]  mem_wdata, mem_rdata;
    modport master (output req_valid, req_we, req_addr, data_b, mem_rdata,
                    input req_ready, q_b, done, busy, align_err, mem_addr, mem_wdata, mem_we, mem_re);
    modport slave  (input req_valid, req_we, req_addr, data_b, mem_rdata,
                    output req_ready, q_b, done, busy, align_err, mem_addr, mem_wdata, mem_we, mem_re);
endinterface

// File: rtl/vmem_beat_gather.sv
// vmem_beat_gather: collects returning RAM words into a load vector and strobes commit on the last beat
//   clk, reset (sync, active-low), re: read strobe issued to the RAM, rdata: RAM read data
//   commit: last beat present this cycle, commit_data: complete vector to load into q_b
module vmem_beat_gather
    import vmem_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             re,
    input  logic [BUS_W-1:0] rdata,
    output logic             commit,
    output logic [VEC_W-1:0] commit_data
);
    logic [MEM_LAT-1:0]          pipe;
    logic [BEAT_IDX_W-1:0]       ret_cnt;
    logic [VEC_W-BUS_W-1:0]      stage;
    logic                        rd_valid;

    // re delayed by MEM_LAT marks the cycles in which rdata is meaningful
    assign rd_valid    = pipe[MEM_LAT-1];
    assign commit      = rd_valid && ret_cnt == BEAT_IDX_W'(BEATS - 1);
    // Earlier beats shift down so beat 0 lands in the low word; the final beat bypasses the stage
    assign commit_data = {rdata, stage};

    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe    <= '0;
            ret_cnt <= '0;
            stage   <= '0;
        end else begin
            pipe <= MEM_LAT'({pipe, re});
            if (rd_valid) begin
                stage   <= {rdata, stage[VEC_W-BUS_W-1:BUS_W]};
                ret_cnt <= ret_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/vector_mem_bridge.sv
// vector_mem_bridge: splits 128-bit vector stores into 4 RAM words and gathers 4 RAM words into a load vector
//   clk, reset (sync, active-low), bus: vector_mem_bridge_if.slave
//   VMEM_ALIGN_CHECK_EN: reject bases with req_addr[3:0]!=0 via done+align_err; otherwise the base is forced 16-byte aligned
module vector_mem_bridge
    import vmem_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    vector_mem_bridge_if.slave  bus
);
    vmem_state_t           state, state_n;
    logic [BEAT_IDX_W-1:0] iss_cnt;
    logic [ADDR_W-1:0]     base_r, base_in;
    logic [VEC_W-1:0]      data_r, q_r, commit_data;
    logic                  accept, mis, commit, issuing;

    assign accept  = bus.req_valid && state == IDLE;
    assign issuing = state == WRITE || state == READ;

`ifdef VMEM_ALIGN_CHECK_EN
    logic err_r;
    assign mis           = |bus.req_addr[3:0];
    assign base_in       = bus.req_addr;
    assign bus.align_err = state == DONE && err_r;
    always_ff @(posedge clk) begin
        if (!reset) err_r <= 1'b0;
        else if (accept) err_r <= mis;
    end
`else
    assign mis           = 1'b0;
    assign base_in       = bus.req_addr & ~ADDR_W'(4'hF);
    assign bus.align_err = 1'b0;
`endif

    vmem_beat_gather #(.MEM_LAT(MEM_LAT)) u_gather (
        .clk         (clk),
        .reset       (reset),
        .re          (bus.mem_re),
        .rdata       (bus.mem_rdata),
        .commit      (commit),
        .commit_data (commit_data)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !accept ? IDLE : mis ? DONE : bus.req_we ? WRITE : READ;
            WRITE:   state_n = iss_cnt == BEAT_IDX_W'(BEATS - 1) ? DONE : WRITE;
            READ:    state_n = iss_cnt == BEAT_IDX_W'(BEATS - 1) ? DRAIN : READ;
            DRAIN:   state_n = commit ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            iss_cnt <= '0;
            base_r  <= '0;
            data_r  <= '0;
            q_r     <= '0;
        end else begin
            state   <= state_n;
            iss_cnt <= issuing ? iss_cnt + 1'b1 : '0;
            if (accept) begin
                base_r <= base_in;
                data_r <= bus.data_b;
            end
            if (commit) q_r <= commit_data;
        end
    end

    assign bus.req_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.done      = state == DONE;
    assign bus.q_b       = q_r;
    assign bus.mem_we    = state == WRITE;
    assign bus.mem_re    = state == READ;
    assign bus.mem_addr  = issuing ? beat_addr(base_r, iss_cnt) : '0;
    assign bus.mem_wdata = state == WRITE ? data_r[BUS_W*iss_cnt +: BUS_W] : '0;
endmodule
